regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default `XLEN (64), register data width.
REQ-002 SHALL have parameter AW, default `reg_addr_width (5), register address width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, consecutive cycles port B may lose before it is forced to win.
REQ-004 clk  input  1  single clock, all state on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 a_valid/a_ready  in/out  1/1  pipeline writeback request/accept.
REQ-007 a_addr/a_data  input  AW/XLEN  pipeline destination and value.
REQ-008 b_valid/b_ready  in/out  1/1  multi-cycle unit (MDU) writeback request/accept.
REQ-009 b_addr/b_data  input  AW/XLEN  MDU destination and value.
REQ-010 wr_en/wr_addr/wr_data  output  1/AW/XLEN  registered regfile write port.
REQ-011 sb_set/sb_addr  input  1/AW  MDU issue: marks sb_addr pending.
REQ-012 rs1_addr/rs2_addr  input  AW/AW  decode-stage source addresses.
REQ-013 hazard_o  output  1  source register has a pending MDU write.

Function
REQ-014 Handshake SHALL complete on a port in the cycle valid and ready are both high; ready SHALL depend on valid inputs and internal state only, never on the requester's address or data.
REQ-015 Only one port SHALL be granted per cycle; port A wins by default.
REQ-016 A 2-bit starvation counter SHALL increment each cycle b_valid=1 and b_ready=0, saturating at STARVE_MAX.
REQ-017 When the counter equals STARVE_MAX, port B SHALL win over port A. The counter SHALL clear on a B handshake.
REQ-018 The granted request SHALL appear on wr_en/wr_addr/wr_data exactly one cycle after its handshake. wr_en SHALL be 0 in cycles with no handshake.
REQ-019 A handshake with addr=0 SHALL complete normally but produce wr_en=0.
REQ-020 The arbiter SHALL be able to accept a new handshake every cycle (no bubbles).
REQ-021 A 32-bit pending scoreboard SHALL set bit sb_addr on sb_set=1 and clear bit b_addr on a B handshake.
REQ-022 If set and clear hit the same address in the same cycle, set SHALL win.
REQ-023 sb_set with sb_addr=0 SHALL be ignored.
REQ-024 hazard_o SHALL be combinational: pending[rs1_addr] OR pending[rs2_addr], with address 0 never hazardous.
REQ-025 A port-A write SHALL NOT alter scoreboard state.

Reset
REQ-026 On rst=1 at posedge: wr_en=0, wr_addr=0, wr_data=0, starvation counter=0, all scoreboard bits=0. This SHALL hold even mid-transfer; an in-flight registered write is dropped.
REQ-027 While rst=1, a_ready and b_ready SHALL be 0.

Configuration
REQ-028 Macro WB_SCOREBOARD_EN: when defined, the scoreboard and hazard_o SHALL be implemented per REQ-021..025.
REQ-029 When WB_SCOREBOARD_EN is undefined, hazard_o SHALL be tied to 0, sb_set/sb_addr SHALL be ignored, and no scoreboard flops SHALL exist.

Structure
REQ-030 XLEN, AW, and the STARVE_MAX default SHALL come from the shared defines/package, along with a grant encoding typedef (GNT_NONE, GNT_A, GNT_B).
REQ-031 The scoreboard SHALL be a sub-module wb_scoreboard: set/clear ports plus two read ports.

Verification
REQ-032 a_valid=1 (addr 5, data 0x11) and b_valid=1 (addr 6, data 0x22) same cycle -> a_ready=1, b_ready=0; next cycle wr_en=1, wr_addr=5, wr_data=0x11.
REQ-033 a_valid held 1 continuously with b_valid=1 -> B loses 3 cycles, wins on the 4th; wr_addr=B's address one cycle later; counter returns to 0.
REQ-034 sb_set addr 7, then rs1_addr=7 -> hazard_o=1. B handshake on addr 7 -> hazard_o=0 the cycle after.
REQ-035 sb_set addr 9 and B handshake addr 9 in the same cycle -> bit 9 stays set, hazard_o=1 for rs2_addr=9.
REQ-036 A handshake with addr 0, data 0xFFFF -> a_ready=1, next cycle wr_en=0. sb_set addr 0 -> hazard_o=0 for rs1_addr=0.
REQ-037 rst pulsed the cycle after a handshake -> wr_en=0, hazard_o=0 for all addresses, counter=0. Repeat with WB_SCOREBOARD_EN undefined -> hazard_o always 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, starvation limit and grant encoding for the writeback arbiter.
// The macro WB_SCOREBOARD_EN (checked in the top) enables the pending-write scoreboard.
package regfile_wb_arbiter_pkg;
  localparam int WB_XLEN       = 64;
  localparam int WB_AW         = 5;
  localparam int WB_STARVE_MAX = 3;
  localparam int STARVE_W      = 2;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_t;

  // Saturating increment of the starvation counter.
  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt,
                                                     input logic [STARVE_W-1:0] max);
    return (cnt == max) ? cnt : cnt + STARVE_W'(1);
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on MDU issue, cleared on MDU writeback.
// Register 0 is never pending; a set and clear on the same address leaves the bit set.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int AW = WB_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rd0_addr,
  input  logic [AW-1:0] rd1_addr,
  output logic          rd0_pend,
  output logic          rd1_pend
);
  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0] pend_reg;
  logic [DEPTH-1:0] pend_next;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
    if (gi == 0) begin : g_zero
      assign pend_next[gi] = 1'b0;
    end else begin : g_live
      logic set_hit;
      logic clr_hit;
      assign set_hit       = set_en && (set_addr == AW'(gi));
      assign clr_hit       = clr_en && (clr_addr == AW'(gi));
      assign pend_next[gi] = set_hit || (pend_reg[gi] && !clr_hit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pend_reg <= '0;
    else     pend_reg <= pend_next;
  end

  assign rd0_pend = (rd0_addr != '0) && pend_reg[rd0_addr];
  assign rd1_pend = (rd1_addr != '0) && pend_reg[rd1_addr];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port regfile writeback arbiter: pipeline (A) wins by default, MDU (B) is forced through
// after STARVE_MAX lost cycles. Define WB_SCOREBOARD_EN to build the pending-write scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN       = WB_XLEN,
  parameter int AW         = WB_AW,
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_addr,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_addr,
  input  logic [XLEN-1:0] b_data,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [XLEN-1:0] wr_data,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_addr,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            hazard_o
);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  grant_t               grant;
  logic [STARVE_W-1:0]  starve_reg;
  logic [STARVE_W-1:0]  starve_next;
  logic                 force_b;
  logic                 wr_en_reg;
  logic [AW-1:0]        wr_addr_reg;
  logic [XLEN-1:0]      wr_data_reg;

  assign force_b = (starve_reg == STARVE_LIM);

  // Grant depends only on valids, reset and the starvation counter, never on addr/data.
  always_comb begin
    grant = GNT_NONE;
    if (!rst) begin
      if (b_valid && (force_b || !a_valid)) grant = GNT_B;
      else if (a_valid)                     grant = GNT_A;
    end
  end

  assign a_ready = (grant == GNT_A);
  assign b_ready = (grant == GNT_B);

  always_comb begin
    starve_next = starve_reg;
    if (grant == GNT_B)  starve_next = '0;
    else if (b_valid)    starve_next = starve_inc(starve_reg, STARVE_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_reg  <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      starve_reg <= starve_next;
      case (grant)
        GNT_A: begin
          wr_en_reg   <= (a_addr != '0);
          wr_addr_reg <= a_addr;
          wr_data_reg <= a_data;
        end
        GNT_B: begin
          wr_en_reg   <= (b_addr != '0);
          wr_addr_reg <= b_addr;
          wr_data_reg <= b_data;
        end
        default: wr_en_reg <= 1'b0;
      endcase
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

`ifdef WB_SCOREBOARD_EN
  logic rs1_pend;
  logic rs2_pend;

  wb_scoreboard #(.AW(AW)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set && (sb_addr != '0)),
    .set_addr (sb_addr),
    .clr_en   (grant == GNT_B),
    .clr_addr (b_addr),
    .rd0_addr (rs1_addr),
    .rd1_addr (rs2_addr),
    .rd0_pend (rs1_pend),
    .rd1_pend (rs2_pend)
  );

  assign hazard_o = rs1_pend || rs2_pend;
`else
  logic unused_sb;
  assign unused_sb = ^{sb_set, sb_addr, rs1_addr, rs2_addr};
  assign hazard_o  = 1'b0;
`endif
endmodule
